mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT, default 15, SHALL set the maximum number of WAIT cycles allowed without dmem_ack (range 1..15).
REQ-002 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  SHALL be the reset; one clock, and reset is asynchronous and active-high.
REQ-004 ex_valid  in  1  SHALL mean the Execute-stage result is valid this cycle.
REQ-005 ex_ready  out  1  SHALL mean this stage accepts an Execute result this cycle.
REQ-006 ex_alu_out  in  16  SHALL carry the ALU result, which is also the memory address.
REQ-007 ex_store_data  in  16  SHALL carry the store data.
REQ-008 ex_mem_rd  in  1  and ex_mem_wr  in  1  SHALL mark the operation as a load or a store.
REQ-009 ex_wb_en  in  1  and ex_wb_reg  in  4  SHALL give the register-writeback enable and the destination register.
REQ-010 dmem_req  out  1, dmem_we  out  1, dmem_addr  out  16, dmem_wdata  out  16  SHALL form the data-memory request.
REQ-011 dmem_ack  in  1  and dmem_rdata  in  16  SHALL form the data-memory response.
REQ-012 wb_valid  out  1, wb_en  out  1, wb_reg  out  4, wb_data  out  16  SHALL form the writeback output.
REQ-013 mem_err  out  1  SHALL be a sticky error flag.

Function
REQ-014 The FSM SHALL have three states, IDLE, WAIT and RETIRE; ex_ready SHALL equal (state==IDLE).
REQ-015 A transfer SHALL occur when ex_valid and ex_ready are both 1; ex_valid while not ready SHALL be ignored, and upstream SHALL hold it.
REQ-016 On a transfer of a non-memory op (rd=0, wr=0), the stage SHALL go to RETIRE, with wb_data=ex_alu_out, wb_en=ex_wb_en and wb_reg=ex_wb_reg registered.
REQ-017 On a transfer with exactly one of rd/wr set, the stage SHALL go to WAIT, registering dmem_addr={ex_alu_out[15:1],1'b0}, dmem_wdata=ex_store_data and dmem_we=ex_mem_wr.
REQ-018 In WAIT, dmem_req SHALL be 1, and dmem_addr, dmem_we and dmem_wdata SHALL stay stable until the ack or the timeout.
REQ-019 A dmem_ack in WAIT SHALL move the stage to RETIRE; on a load, wb_data SHALL capture dmem_rdata and wb_en=ex_wb_en.
REQ-020 A store SHALL retire with wb_en=0.
REQ-021 dmem_ack in the same cycle dmem_req first rises SHALL be legal.
REQ-022 dmem_ack outside WAIT SHALL be ignored.
REQ-023 A 4-bit wait counter SHALL clear on entry to WAIT and increment each WAIT cycle without ack.
REQ-024 When the wait counter reaches TIMEOUT, the stage SHALL drop dmem_req, set mem_err, and go to RETIRE with wb_en=0.
REQ-025 A transfer with rd=1 and wr=1 SHALL issue no memory request, SHALL set mem_err, and SHALL go to RETIRE with wb_en=0.
REQ-026 In RETIRE, wb_valid SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE.
REQ-027 Latency: a non-memory op accepted in cycle T SHALL give wb_valid in T+1.
REQ-028 Latency: a memory op accepted in T with ack in T+k (k>=1) SHALL give wb_valid in T+k+1.
REQ-029 The next acceptance SHALL be no earlier than the cycle after wb_valid.
REQ-030 wb_en, wb_reg and wb_data SHALL hold their values when wb_valid=0.
REQ-031 mem_err SHALL clear only on reset.

Reset
REQ-032 rst=1 SHALL, asynchronously, force state=IDLE and the wait counter to 0.
REQ-033 rst=1 SHALL, asynchronously, force dmem_req=0, dmem_we=0, dmem_addr=0 and dmem_wdata=0.
REQ-034 rst=1 SHALL, asynchronously, force wb_valid=0, wb_en=0, wb_reg=0, wb_data=0 and mem_err=0.
REQ-035 Reset during WAIT SHALL abandon the access: dmem_req SHALL fall in the same cycle, and no wb_valid SHALL follow.
REQ-036 Normal operation SHALL resume on the first rising edge after rst deasserts.

Structure
REQ-037 Package mem_stage_pkg SHALL hold the state enum (IDLE/WAIT/RETIRE), the TIMEOUT default and the 16-bit data/address width constants.
REQ-038 The FSM plus the wait counter SHALL be one sub-module, mem_req_fsm; the datapath registers SHALL live in mem_stage.

Verification
REQ-039 The bench SHALL apply a non-memory op (alu_out=0x1234, wb_en=1, wb_reg=3) and SHALL check wb_valid one cycle later with wb_data=0x1234, wb_en=1, wb_reg=3, and dmem_req never asserted.
REQ-040 The bench SHALL apply a load (addr 0x0041) with ack 3 cycles after req and rdata=0xBEEF, and SHALL check dmem_addr=0x0040, dmem_we=0, wb_data=0xBEEF, and ex_ready=0 throughout WAIT.
REQ-041 The bench SHALL apply a store (addr 0x0100, data 0xA5A5) with ack in the same cycle as req, and SHALL check dmem_we=1, dmem_wdata=0xA5A5, wb_valid in T+2 and wb_en=0.
REQ-042 The bench SHALL apply a load with ack never arriving and TIMEOUT=15, and SHALL check dmem_req drops after 15 WAIT cycles, mem_err=1 stays sticky, and wb_en=0.
REQ-043 The bench SHALL apply rd=wr=1, and SHALL check no dmem_req, mem_err=1, and wb_valid in T+1 with wb_en=0.
REQ-044 The bench SHALL pulse rst mid-WAIT, and SHALL check dmem_req=0 immediately, no wb_valid, and a subsequent op completing normally.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory pipeline stage.
package mem_stage_pkg;

    localparam int DATA_W          = 16;
    localparam int ADDR_W          = 16;
    localparam int REG_W           = 4;
    localparam int CNT_W           = 4;
    localparam int DEFAULT_TIMEOUT = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        RETIRE = 2'd2
    } state_t;

endpackage

// File: rtl/mem_stage_if.sv
// Execute-side input, data-memory request/response and writeback bundle for mem_stage.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic              ex_valid;
    logic              ex_ready;
    logic [DATA_W-1:0] ex_alu_out;
    logic [DATA_W-1:0] ex_store_data;
    logic              ex_mem_rd;
    logic              ex_mem_wr;
    logic              ex_wb_en;
    logic [REG_W-1:0]  ex_wb_reg;

    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ack;
    logic [DATA_W-1:0] dmem_rdata;

    logic              wb_valid;
    logic              wb_en;
    logic [REG_W-1:0]  wb_reg;
    logic [DATA_W-1:0] wb_data;
    logic              mem_err;

    // master: the surrounding pipeline and memory; slave: the stage itself
    modport master (
        output ex_valid, ex_alu_out, ex_store_data, ex_mem_rd, ex_mem_wr, ex_wb_en, ex_wb_reg,
        output dmem_ack, dmem_rdata,
        input  ex_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  wb_valid, wb_en, wb_reg, wb_data, mem_err
    );

    modport slave (
        input  ex_valid, ex_alu_out, ex_store_data, ex_mem_rd, ex_mem_wr, ex_wb_en, ex_wb_reg,
        input  dmem_ack, dmem_rdata,
        output ex_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output wb_valid, wb_en, wb_reg, wb_data, mem_err
    );

endinterface

// File: rtl/mem_stage_req_fsm.sv
// IDLE/WAIT/RETIRE sequencer with wait-cycle counter; one op in flight, ready only in IDLE.
// Emits single-cycle events (ack taken, timeout, rd+wr conflict) for the datapath.
module mem_req_fsm
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_ex_valid,
    input  logic i_mem_rd,
    input  logic i_mem_wr,
    input  logic i_dmem_ack,
    output logic o_ex_ready,
    output logic o_dmem_req,
    output logic o_ack_take,
    output logic o_timeout,
    output logic o_both_err
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_cnt_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_wait_cnt_next;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        case (r_state)
            IDLE: begin
                if (i_ex_valid) begin
                    if (i_mem_rd ^ i_mem_wr) begin
                        w_next_state    = WAIT;
                        w_wait_cnt_next = '0;
                    end else begin
                        w_next_state = RETIRE;
                    end
                end
            end
            WAIT: begin
                if (i_dmem_ack) begin
                    w_next_state = RETIRE;
                end else begin
                    // counter lands on TIMEOUT on the same edge the stage gives up
                    w_wait_cnt_next = r_wait_cnt + 1'b1;
                    if (r_wait_cnt == LAST_CNT) begin
                        w_next_state = RETIRE;
                    end
                end
            end
            RETIRE:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        o_ex_ready = (r_state == IDLE);
        o_dmem_req = (r_state == WAIT);
        o_ack_take = (r_state == WAIT) && i_dmem_ack;
        o_timeout  = (r_state == WAIT) && !i_dmem_ack && (r_wait_cnt == LAST_CNT);
        o_both_err = (r_state == IDLE) && i_ex_valid && i_mem_rd && i_mem_wr;
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: non-memory ops retire in 1 cycle, loads/stores 1 cycle after ack.
// Accepts a new op only in IDLE; upstream holds ex_valid until ex_ready.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    mem_stage_if.slave    io_mem
);

    logic w_ex_ready;
    logic w_dmem_req;
    logic w_ack_take;
    logic w_timeout;
    logic w_both_err;
    logic w_xfer;

    logic              r_dmem_we;
    logic [ADDR_W-1:0] r_dmem_addr;
    logic [DATA_W-1:0] r_dmem_wdata;
    logic              r_is_load;
    logic              r_pend_wb_en;
    logic [REG_W-1:0]  r_pend_wb_reg;
    logic              r_wb_en;
    logic [REG_W-1:0]  r_wb_reg;
    logic [DATA_W-1:0] r_wb_data;
    logic              r_mem_err;

    mem_req_fsm #(.TIMEOUT(TIMEOUT)) u_fsm (
        .clk        (clk),
        .rst        (rst),
        .i_ex_valid (io_mem.ex_valid),
        .i_mem_rd   (io_mem.ex_mem_rd),
        .i_mem_wr   (io_mem.ex_mem_wr),
        .i_dmem_ack (io_mem.dmem_ack),
        .o_ex_ready (w_ex_ready),
        .o_dmem_req (w_dmem_req),
        .o_ack_take (w_ack_take),
        .o_timeout  (w_timeout),
        .o_both_err (w_both_err)
    );

    assign w_xfer = io_mem.ex_valid && w_ex_ready;

    // writeback outputs only change on the edge into RETIRE, so they hold otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dmem_we     <= 1'b0;
            r_dmem_addr   <= '0;
            r_dmem_wdata  <= '0;
            r_is_load     <= 1'b0;
            r_pend_wb_en  <= 1'b0;
            r_pend_wb_reg <= '0;
            r_wb_en       <= 1'b0;
            r_wb_reg      <= '0;
            r_wb_data     <= '0;
            r_mem_err     <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_is_load     <= io_mem.ex_mem_rd;
                r_pend_wb_en  <= io_mem.ex_wb_en;
                r_pend_wb_reg <= io_mem.ex_wb_reg;
                if (io_mem.ex_mem_rd ^ io_mem.ex_mem_wr) begin
                    r_dmem_addr  <= {io_mem.ex_alu_out[ADDR_W-1:1], 1'b0};
                    r_dmem_wdata <= io_mem.ex_store_data;
                    r_dmem_we    <= io_mem.ex_mem_wr;
                end else begin
                    r_wb_en  <= io_mem.ex_wb_en && !io_mem.ex_mem_rd;
                    r_wb_reg <= io_mem.ex_wb_reg;
                    if (!io_mem.ex_mem_rd) begin
                        r_wb_data <= io_mem.ex_alu_out;
                    end
                end
            end
            if (w_ack_take) begin
                r_wb_en  <= r_is_load && r_pend_wb_en;
                r_wb_reg <= r_pend_wb_reg;
                if (r_is_load) begin
                    r_wb_data <= io_mem.dmem_rdata;
                end
            end
            if (w_timeout) begin
                r_wb_en  <= 1'b0;
                r_wb_reg <= r_pend_wb_reg;
            end
            if (w_timeout || w_both_err) begin
                r_mem_err <= 1'b1;
            end
        end
    end

    assign io_mem.ex_ready   = w_ex_ready;
    assign io_mem.dmem_req   = w_dmem_req;
    assign io_mem.dmem_we    = r_dmem_we;
    assign io_mem.dmem_addr  = r_dmem_addr;
    assign io_mem.dmem_wdata = r_dmem_wdata;
    assign io_mem.wb_valid   = !w_ex_ready && !w_dmem_req;
    assign io_mem.wb_en      = r_wb_en;
    assign io_mem.wb_reg     = r_wb_reg;
    assign io_mem.wb_data    = r_wb_data;
    assign io_mem.mem_err    = r_mem_err;

endmodule

// File: tb/tb_mem_stage.sv
// Directed test of mem_stage: ALU op, load, store, stray ack, rd+wr conflict, reset mid-WAIT, timeout.
module tb_mem_stage;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_wait;

    mem_stage_if mif ();

    mem_stage #(.TIMEOUT(15)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_mem (mif)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] alu, input logic [15:0] sdat, input logic rd,
                        input logic wr, input logic en, input logic [3:0] rg);
        mif.ex_valid      = 1'b1;
        mif.ex_alu_out    = alu;
        mif.ex_store_data = sdat;
        mif.ex_mem_rd     = rd;
        mif.ex_mem_wr     = wr;
        mif.ex_wb_en      = en;
        mif.ex_wb_reg     = rg;
    endtask

    initial begin
        rst = 1'b1;
        mif.ex_valid = 1'b0; mif.ex_alu_out = '0; mif.ex_store_data = '0;
        mif.ex_mem_rd = 1'b0; mif.ex_mem_wr = 1'b0; mif.ex_wb_en = 1'b0; mif.ex_wb_reg = '0;
        mif.dmem_ack = 1'b0; mif.dmem_rdata = '0;
        step(); step();

        chk("rst_ready",    mif.ex_ready,   1);
        chk("rst_req",      mif.dmem_req,   0);
        chk("rst_we",       mif.dmem_we,    0);
        chk("rst_addr",     mif.dmem_addr,  0);
        chk("rst_wdata",    mif.dmem_wdata, 0);
        chk("rst_wb_valid", mif.wb_valid,   0);
        chk("rst_wb_en",    mif.wb_en,      0);
        chk("rst_wb_reg",   mif.wb_reg,     0);
        chk("rst_wb_data",  mif.wb_data,    0);
        chk("rst_mem_err",  mif.mem_err,    0);
        rst = 1'b0;

        // ALU op: retires the cycle after acceptance
        send(16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1, 4'd3);
        step();
        chk("alu_wb_valid", mif.wb_valid, 1);
        chk("alu_wb_data",  mif.wb_data,  16'h1234);
        chk("alu_wb_en",    mif.wb_en,    1);
        chk("alu_wb_reg",   mif.wb_reg,   3);
        chk("alu_req",      mif.dmem_req, 0);
        chk("alu_ready",    mif.ex_ready, 0);
        mif.ex_valid = 1'b0;
        step();
        chk("alu_wb_valid_off", mif.wb_valid, 0);
        chk("alu_ready_back",   mif.ex_ready, 1);
        chk("alu_hold_data",    mif.wb_data,  16'h1234);
        chk("alu_hold_en",      mif.wb_en,    1);
        chk("alu_req_idle",     mif.dmem_req, 0);

        // Load at 0x0041, ack 3 cycles after req rises
        send(16'h0041, 16'h7777, 1'b1, 1'b0, 1'b1, 4'd5);
        step();
        mif.ex_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("ld_req",   mif.dmem_req,  1);
            chk("ld_ready", mif.ex_ready,  0);
            chk("ld_addr",  mif.dmem_addr, 16'h0040);
            chk("ld_we",    mif.dmem_we,   0);
            step();
        end
        chk("ld_req_ack",   mif.dmem_req, 1);
        chk("ld_ready_ack", mif.ex_ready, 0);
        mif.dmem_ack = 1'b1; mif.dmem_rdata = 16'hBEEF;
        step();
        mif.dmem_ack = 1'b0; mif.dmem_rdata = 16'h0000;
        chk("ld_wb_valid", mif.wb_valid, 1);
        chk("ld_wb_data",  mif.wb_data,  16'hBEEF);
        chk("ld_wb_en",    mif.wb_en,    1);
        chk("ld_wb_reg",   mif.wb_reg,   5);
        chk("ld_req_off",  mif.dmem_req, 0);
        step();
        chk("ld_wb_valid_off", mif.wb_valid, 0);
        chk("ld_ready_back",   mif.ex_ready, 1);

        // Store at 0x0100, ack in the first request cycle
        send(16'h0100, 16'hA5A5, 1'b0, 1'b1, 1'b1, 4'd7);
        step();
        mif.ex_valid = 1'b0;
        chk("st_req",   mif.dmem_req,   1);
        chk("st_we",    mif.dmem_we,    1);
        chk("st_wdata", mif.dmem_wdata, 16'hA5A5);
        chk("st_addr",  mif.dmem_addr,  16'h0100);
        mif.dmem_ack = 1'b1;
        step();
        mif.dmem_ack = 1'b0;
        chk("st_wb_valid", mif.wb_valid, 1);
        chk("st_wb_en",    mif.wb_en,    0);
        chk("st_wb_reg",   mif.wb_reg,   7);
        chk("st_req_off",  mif.dmem_req, 0);
        step();
        chk("st_wb_valid_off", mif.wb_valid, 0);

        // Ack while idle must be ignored
        mif.dmem_ack = 1'b1; mif.dmem_rdata = 16'h1111;
        step();
        mif.dmem_ack = 1'b0; mif.dmem_rdata = 16'h0000;
        chk("stray_wb_valid", mif.wb_valid, 0);
        chk("stray_wb_data",  mif.wb_data,  16'hBEEF);
        chk("stray_ready",    mif.ex_ready, 1);
        step();
        chk("stray_wb_valid2", mif.wb_valid, 0);

        // rd and wr both set: immediate error retire, no request
        chk("both_err_pre", mif.mem_err, 0);
        send(16'h0300, 16'h0000, 1'b1, 1'b1, 1'b1, 4'd2);
        step();
        mif.ex_valid = 1'b0;
        chk("both_wb_valid", mif.wb_valid, 1);
        chk("both_wb_en",    mif.wb_en,    0);
        chk("both_wb_reg",   mif.wb_reg,   2);
        chk("both_req",      mif.dmem_req, 0);
        chk("both_mem_err",  mif.mem_err,  1);
        step();
        chk("both_wb_valid_off", mif.wb_valid, 0);
        chk("both_err_sticky",   mif.mem_err,  1);

        // Reset in the middle of a WAIT
        send(16'h0400, 16'h0000, 1'b1, 1'b0, 1'b1, 4'd4);
        step();
        mif.ex_valid = 1'b0;
        chk("rw_req1", mif.dmem_req, 1);
        step();
        chk("rw_req2", mif.dmem_req, 1);
        rst = 1'b1;
        #1;
        chk("rw_req_async", mif.dmem_req,  0);
        chk("rw_wb_valid",  mif.wb_valid,  0);
        chk("rw_mem_err",   mif.mem_err,   0);
        chk("rw_addr",      mif.dmem_addr, 0);
        chk("rw_ready",     mif.ex_ready,  1);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rw_no_wb_valid", mif.wb_valid, 0);
            chk("rw_no_req",      mif.dmem_req, 0);
            step();
        end
        send(16'h5555, 16'h0000, 1'b0, 1'b0, 1'b1, 4'd6);
        step();
        mif.ex_valid = 1'b0;
        chk("rw_op_wb_valid", mif.wb_valid, 1);
        chk("rw_op_wb_data",  mif.wb_data,  16'h5555);
        chk("rw_op_wb_reg",   mif.wb_reg,   6);
        chk("rw_op_wb_en",    mif.wb_en,    1);
        step();

        // Load that is never acknowledged: 15 WAIT cycles then error retire
        chk("to_err_pre", mif.mem_err, 0);
        send(16'h0200, 16'h0000, 1'b1, 1'b0, 1'b1, 4'd9);
        step();
        mif.ex_valid = 1'b0;
        n_wait = 0;
        while (mif.dmem_req === 1'b1 && n_wait < 40) begin
            chk("to_ready", mif.ex_ready, 0);
            n_wait++;
            step();
        end
        chk("to_wait_cycles", n_wait,        15);
        chk("to_wb_valid",    mif.wb_valid,  1);
        chk("to_wb_en",       mif.wb_en,     0);
        chk("to_wb_reg",      mif.wb_reg,    9);
        chk("to_mem_err",     mif.mem_err,   1);
        chk("to_addr_held",   mif.dmem_addr, 16'h0200);
        step();
        chk("to_wb_valid_off", mif.wb_valid, 0);
        chk("to_ready_back",   mif.ex_ready, 1);
        step(); step();
        chk("to_err_sticky",   mif.mem_err,  1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
